// File: rtl/bus_fifo_pkg.sv
// bus_fifo_pkg: shared types, defaults and width helpers for the bus driver FIFO bank.
package bus_fifo_pkg;

    typedef enum logic {
        OVF_DROP_NEW = 1'b0,
        OVF_DROP_OLD = 1'b1
    } ovf_mode_e;

    localparam int PCKG_SZ_DEF = 16;

    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/bus_chan_fifo.sv
// bus_chan_fifo: one first-word-fall-through FIFO with a selectable full-write policy.
module bus_chan_fifo
    import bus_fifo_pkg::*;
#(
    parameter int        pckg_sz  = PCKG_SZ_DEF,
    parameter int        depth    = 8,
    parameter ovf_mode_e ovf_mode = OVF_DROP_NEW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [pckg_sz-1:0]        wdata,
    input  logic                      rd,
    output logic [pckg_sz-1:0]        rdata,
    output logic                      valid,
    output logic [cnt_w(depth)-1:0]   count,
    output logic                      ovf_ev,
    output logic                      udf_ev
);

    localparam int aw = $clog2(depth);
    localparam int cw = cnt_w(depth);

    logic [pckg_sz-1:0] mem [depth];
    logic [aw-1:0]      wp, rp;
    logic               empty, full, do_wr, adv_rd;

    // a full write with a concurrent read is a plain exchange, never an overflow
    always_comb begin
        empty  = count == '0;
        full   = count == cw'(depth);
        do_wr  = wr && (!full || rd || ovf_mode == OVF_DROP_OLD);
        adv_rd = (rd && !empty) || (wr && full && !rd && ovf_mode == OVF_DROP_OLD);
        ovf_ev = wr && full && !rd;
        udf_ev = rd && empty;
        valid  = !empty;
        rdata  = empty ? '0 : mem[rp];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + aw'(do_wr);
            rp    <= rp + aw'(adv_rd);
            count <= count + cw'(do_wr) - cw'(adv_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end

endmodule

// File: rtl/bus_drvr_fifo_bank.sv
// bus_drvr_fifo_bank: per-device TX/RX FIFO pairs between the driver side and the bus,
// with sticky overflow/underflow flags per channel.
module bus_drvr_fifo_bank
    import bus_fifo_pkg::*;
#(
    parameter int        drvrs    = 4,
    parameter int        pckg_sz  = PCKG_SZ_DEF,
    parameter int        depth    = 8,
    parameter ovf_mode_e ovf_mode = OVF_DROP_NEW
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [drvrs-1:0]                  tx_wr,
    input  logic [drvrs*pckg_sz-1:0]          tx_wdata,
    output logic [drvrs-1:0]                  pndng,
    output logic [drvrs*pckg_sz-1:0]          D_pop,
    input  logic [drvrs-1:0]                  pop,
    input  logic [drvrs-1:0]                  push,
    input  logic [drvrs*pckg_sz-1:0]          D_push,
    output logic [drvrs-1:0]                  rx_valid,
    output logic [drvrs*pckg_sz-1:0]          rx_rdata,
    input  logic [drvrs-1:0]                  rx_rd,
    output logic [drvrs*cnt_w(depth)-1:0]     tx_count,
    output logic [drvrs*cnt_w(depth)-1:0]     rx_count,
    output logic [drvrs-1:0]                  ovf_flag,
    output logic [drvrs-1:0]                  udf_flag,
    input  logic                              clr_flags
);

    localparam int cw = cnt_w(depth);

    logic [drvrs-1:0] tx_ovf, tx_udf, rx_ovf, rx_udf;

    for (genvar i = 0; i < drvrs; i++) begin : g_ch
        bus_chan_fifo #(.pckg_sz(pckg_sz), .depth(depth), .ovf_mode(ovf_mode)) u_tx (
            .clk    (clk),
            .reset  (reset),
            .wr     (tx_wr[i]),
            .wdata  (tx_wdata[i*pckg_sz +: pckg_sz]),
            .rd     (pop[i]),
            .rdata  (D_pop[i*pckg_sz +: pckg_sz]),
            .valid  (pndng[i]),
            .count  (tx_count[i*cw +: cw]),
            .ovf_ev (tx_ovf[i]),
            .udf_ev (tx_udf[i])
        );
        bus_chan_fifo #(.pckg_sz(pckg_sz), .depth(depth), .ovf_mode(ovf_mode)) u_rx (
            .clk    (clk),
            .reset  (reset),
            .wr     (push[i]),
            .wdata  (D_push[i*pckg_sz +: pckg_sz]),
            .rd     (rx_rd[i]),
            .rdata  (rx_rdata[i*pckg_sz +: pckg_sz]),
            .valid  (rx_valid[i]),
            .count  (rx_count[i*cw +: cw]),
            .ovf_ev (rx_ovf[i]),
            .udf_ev (rx_udf[i])
        );
    end

    // a new error event in the clearing cycle keeps its flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_flag <= '0;
            udf_flag <= '0;
        end else begin
            ovf_flag <= (ovf_flag & ~{drvrs{clr_flags}}) | tx_ovf | rx_ovf;
            udf_flag <= (udf_flag & ~{drvrs{clr_flags}}) | tx_udf | rx_udf;
        end
    end

endmodule

// File: tb/tb_bus_drvr_fifo_bank.sv
// tb_bus_drvr_fifo_bank: table vectors, directed corner sequences and random traffic
// checked against a queue-based model, for both full-write policies side by side.
module tb_bus_drvr_fifo_bank;
    import bus_fifo_pkg::*;

    logic        clk = 1'b0, reset = 1'b0, clr_flags = 1'b0;
    logic [3:0]  tx_wr = '0, pop = '0, push = '0, rx_rd = '0;
    logic [63:0] tx_wdata = '0, D_push = '0;
    logic [3:0]  pndng [2], rx_valid [2], ovf_flag [2], udf_flag [2];
    logic [63:0] D_pop [2], rx_rdata [2];
    logic [11:0] tx_count [2], rx_count [2];

    int n_cmp = 0, n_bad = 0;

    logic [15:0] q [2][2][4][$];
    logic [3:0]  m_ovf [2], m_udf [2];

    always #5 clk = ~clk;

    bus_drvr_fifo_bank #(.drvrs(4), .pckg_sz(16), .depth(4), .ovf_mode(OVF_DROP_NEW)) dut0 (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_wdata(tx_wdata), .pndng(pndng[0]),
        .D_pop(D_pop[0]), .pop(pop), .push(push), .D_push(D_push), .rx_valid(rx_valid[0]),
        .rx_rdata(rx_rdata[0]), .rx_rd(rx_rd), .tx_count(tx_count[0]), .rx_count(rx_count[0]),
        .ovf_flag(ovf_flag[0]), .udf_flag(udf_flag[0]), .clr_flags(clr_flags));

    bus_drvr_fifo_bank #(.drvrs(4), .pckg_sz(16), .depth(4), .ovf_mode(OVF_DROP_OLD)) dut1 (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_wdata(tx_wdata), .pndng(pndng[1]),
        .D_pop(D_pop[1]), .pop(pop), .push(push), .D_push(D_push), .rx_valid(rx_valid[1]),
        .rx_rdata(rx_rdata[1]), .rx_rd(rx_rd), .tx_count(tx_count[1]), .rx_count(rx_count[1]),
        .ovf_flag(ovf_flag[1]), .udf_flag(udf_flag[1]), .clr_flags(clr_flags));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            m_ovf[m] = '0;
            m_udf[m] = '0;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 4; c++) q[m][d][c].delete();
        end
    endtask

    // one clock edge of the behavioural model: mode 1 overwrites the oldest word when full
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic [3:0] eo, eu;
            eo = '0;
            eu = '0;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 4; c++) begin
                    bit w, r, f;
                    logic [15:0] wd;
                    w  = d ? push[c] : tx_wr[c];
                    r  = d ? rx_rd[c] : pop[c];
                    wd = d ? D_push[c*16 +: 16] : tx_wdata[c*16 +: 16];
                    f  = q[m][d][c].size() == 4;
                    if (r) begin
                        if (q[m][d][c].size() == 0) eu[c] = 1'b1;
                        else void'(q[m][d][c].pop_front());
                    end
                    if (w) begin
                        if (f && !r) begin
                            eo[c] = 1'b1;
                            if (m == 1) begin
                                void'(q[m][d][c].pop_front());
                                q[m][d][c].push_back(wd);
                            end
                        end else q[m][d][c].push_back(wd);
                    end
                end
            m_ovf[m] = (clr_flags ? 4'h0 : m_ovf[m]) | eo;
            m_udf[m] = (clr_flags ? 4'h0 : m_udf[m]) | eu;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                int nt, nr;
                nt = q[m][0][c].size();
                nr = q[m][1][c].size();
                chk($sformatf("m%0d ch%0d pndng", m, c), 32'(pndng[m][c]), 32'(nt != 0));
                chk($sformatf("m%0d ch%0d D_pop", m, c), 32'(D_pop[m][c*16 +: 16]),
                    nt != 0 ? 32'(q[m][0][c][0]) : 32'h0);
                chk($sformatf("m%0d ch%0d tx_count", m, c), 32'(tx_count[m][c*3 +: 3]), 32'(nt));
                chk($sformatf("m%0d ch%0d rx_valid", m, c), 32'(rx_valid[m][c]), 32'(nr != 0));
                chk($sformatf("m%0d ch%0d rx_rdata", m, c), 32'(rx_rdata[m][c*16 +: 16]),
                    nr != 0 ? 32'(q[m][1][c][0]) : 32'h0);
                chk($sformatf("m%0d ch%0d rx_count", m, c), 32'(rx_count[m][c*3 +: 3]), 32'(nr));
            end
            chk($sformatf("m%0d ovf_flag", m), 32'(ovf_flag[m]), 32'(m_ovf[m]));
            chk($sformatf("m%0d udf_flag", m), 32'(udf_flag[m]), 32'(m_udf[m]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        tx_wr = '0; pop = '0; push = '0; rx_rd = '0; clr_flags = 1'b0;
        tx_wdata = '0; D_push = '0;
    endtask

    task automatic wr_tx(input int c, input logic [15:0] d);
        tx_wr[c] = 1'b1;
        tx_wdata[c*16 +: 16] = d;
    endtask

    typedef struct {
        logic        wr;
        logic        pp;
        logic [15:0] wd;
        logic        e_pnd;
        logic [15:0] e_dpop;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h0A01, 1'b1, 16'h0A01, 3'd1};
        tbl[1] = '{1'b1, 1'b0, 16'h0A02, 1'b1, 16'h0A01, 3'd2};
        tbl[2] = '{1'b1, 1'b0, 16'h0A03, 1'b1, 16'h0A01, 3'd3};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0A02, 3'd2};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0A03, 3'd1};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0};

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            chk("reset pndng", 32'(pndng[m]), 0);
            chk("reset rx_valid", 32'(rx_valid[m]), 0);
            chk("reset tx_count", 32'(tx_count[m]), 0);
            chk("reset rx_count", 32'(rx_count[m]), 0);
            chk("reset flags", 32'({ovf_flag[m], udf_flag[m]}), 0);
            chk("reset D_pop", D_pop[m][31:0], 0);
        end
        step();

        for (int i = 0; i < 6; i++) begin
            tx_wr[0] = tbl[i].wr;
            pop[0]   = tbl[i].pp;
            tx_wdata[15:0] = tbl[i].wd;
            step();
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("tbl%0d pndng", i), 32'(pndng[m][0]), 32'(tbl[i].e_pnd));
                chk($sformatf("tbl%0d D_pop", i), 32'(D_pop[m][15:0]), 32'(tbl[i].e_dpop));
                chk($sformatf("tbl%0d tx_count", i), 32'(tx_count[m][2:0]), 32'(tbl[i].e_cnt));
            end
        end

        for (int k = 0; k < 5; k++) begin
            wr_tx(2, 16'h2001 + 16'(k));
            step();
        end
        chk("ovf2 cnt m0", 32'(tx_count[0][8:6]), 4);
        chk("ovf2 cnt m1", 32'(tx_count[1][8:6]), 4);
        chk("ovf2 flag m0", 32'(ovf_flag[0][2]), 1);
        chk("ovf2 flag m1", 32'(ovf_flag[1][2]), 1);
        for (int k = 0; k < 4; k++) begin
            chk("ovf2 pop m0", 32'(D_pop[0][47:32]), 32'h2001 + 32'(k));
            chk("ovf2 pop m1", 32'(D_pop[1][47:32]), 32'h2002 + 32'(k));
            pop[2] = 1'b1;
            step();
        end

        clr_flags = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            wr_tx(1, 16'h1001 + 16'(k));
            step();
        end
        wr_tx(1, 16'h1005);
        pop[1] = 1'b1;
        step();
        for (int m = 0; m < 2; m++) begin
            chk("full rw cnt", 32'(tx_count[m][5:3]), 4);
            chk("full rw ovf", 32'(ovf_flag[m][1]), 0);
        end
        for (int k = 0; k < 4; k++) begin
            chk("full rw pop m0", 32'(D_pop[0][31:16]), 32'h1002 + 32'(k));
            chk("full rw pop m1", 32'(D_pop[1][31:16]), 32'h1002 + 32'(k));
            pop[1] = 1'b1;
            step();
        end

        pop[3] = 1'b1;
        rx_rd[3] = 1'b1;
        push[3] = 1'b1;
        D_push[63:48] = 16'h3333;
        step();
        for (int m = 0; m < 2; m++) begin
            chk("rx3 udf", 32'(udf_flag[m][3]), 1);
            chk("rx3 cnt", 32'(rx_count[m][11:9]), 1);
            chk("rx3 data", 32'(rx_rdata[m][63:48]), 32'h3333);
        end
        clr_flags = 1'b1;
        step();
        for (int m = 0; m < 2; m++) chk("rx3 clr", 32'(udf_flag[m][3]), 0);
        rx_rd[3] = 1'b1;
        step();

        for (int k = 0; k < 3; k++) begin
            wr_tx(0, 16'hC000 + 16'(k));
            step();
        end
        reset = 1'b0;
        #1;
        model_clear();
        for (int m = 0; m < 2; m++) begin
            chk("async rst cnt", 32'(tx_count[m][2:0]), 0);
            chk("async rst pndng", 32'(pndng[m][0]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr_tx(0, 16'hBEEF);
        step();
        for (int m = 0; m < 2; m++) chk("post rst D_pop", 32'(D_pop[m][15:0]), 32'hBEEF);

        for (int i = 0; i < 600; i++) begin
            tx_wr    = 4'($urandom);
            pop      = 4'($urandom & $urandom);
            push     = 4'($urandom);
            rx_rd    = 4'($urandom & $urandom);
            tx_wdata = {$urandom, $urandom};
            D_push   = {$urandom, $urandom};
            clr_flags = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_drvr_fifo_bank.md
Name: bus_drvr_fifo_bank

Overview:
Parametrised bank of per-device FIFOs between the verification/driver side and the bus arbiter DUT (bs_gnrtr_n_rbtr).
- TX FIFO per device: buffers packets from the driver side and presents pndng/D_pop to the bus.
- RX FIFO per device: captures push/D_push from the bus and presents packets to the monitor side.
- Generalises the earlier single-depth per-driver queue with configurable depth, overflow policy, occupancy counts and sticky error flags.

Parameters:
- drvrs, 4, number of bus devices/channels (1..16).
- pckg_sz, 16, packet width in bits (>=8).
- depth, 8, entries per FIFO (power of 2, 2..64).
- ovf_mode, 0, full-FIFO write policy: 0 = drop incoming word, 1 = overwrite oldest word.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_wr  in  drvrs  per-channel write strobe from the driver side.
- tx_wdata  in  drvrs*pckg_sz  per-channel write data; channel i occupies bits [i*pckg_sz +: pckg_sz].
- pndng  out  drvrs  TX FIFO non-empty, to the bus.
- D_pop  out  drvrs*pckg_sz  TX FIFO head word, to the bus.
- pop  in  drvrs  bus consumes the TX head.
- push  in  drvrs  bus delivers a word to the device.
- D_push  in  drvrs*pckg_sz  bus delivery data.
- rx_valid  out  drvrs  RX FIFO non-empty.
- rx_rdata  out  drvrs*pckg_sz  RX FIFO head word.
- rx_rd  in  drvrs  monitor consumes the RX head.
- tx_count  out  drvrs*($clog2(depth)+1)  TX occupancy per channel.
- rx_count  out  drvrs*($clog2(depth)+1)  RX occupancy per channel.
- ovf_flag  out  drvrs  sticky; a TX or RX write hit a full FIFO.
- udf_flag  out  drvrs  sticky; pop or rx_rd was issued while the FIFO was empty.
- clr_flags  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset (reset=0, asynchronous): all pointers and counts are 0. pndng, rx_valid, ovf_flag and udf_flag are 0. D_pop and rx_rdata are 0. Storage contents are don't-care, but head outputs are forced to 0 while empty.
- All FIFOs are first-word-fall-through.
  - The head word is visible on D_pop/rx_rdata in the same cycle the flag is 1.
  - A write at edge N makes pndng/rx_valid =1 after edge N, giving 1-cycle write-to-visible latency.
- Read (pop / rx_rd) at edge N with a non-empty FIFO: the head advances after edge N and the count decrements.
- Read on an empty FIFO: ignored. Pointers are unchanged and udf_flag[i] is set.
- Write with count<depth: the word is stored at the tail and the count increments.
- Write with count==depth and no simultaneous read:
  - ovf_mode=0: the word is discarded and the count stays at depth.
  - ovf_mode=1: the word is written at the tail, the head advances and the count stays at depth.
  - In both modes ovf_flag[i] is set.
- Simultaneous read+write when full: both succeed, the count is unchanged, and there is no overflow.
- Simultaneous read+write when empty: the read counts as an underflow (udf set), the write is stored and the count becomes 1.
- Pointers are $clog2(depth) bits and wrap modulo depth. The count is a separate counter of $clog2(depth)+1 bits.
- clr_flags at edge N clears the flags. If an error event occurs in the same cycle, the flag stays set (the set wins).
- Channels are fully independent; there is no cross-channel arbitration in this block.
- Asserting reset mid-burst empties every FIFO immediately. Writes on the first edge after reset deassertion are accepted.

Decomposition:
- Package bus_fifo_pkg holds:
  - the typedef for the ovf_mode enum (OVF_DROP_NEW, OVF_DROP_OLD);
  - a count-width function cnt_w(depth) = $clog2(depth)+1;
  - a localparam default for pckg_sz.
- Sub-module bus_chan_fifo (params pckg_sz, depth, ovf_mode) implements one FWFT FIFO with wr, wdata, rd, rdata, valid, count, ovf_ev and udf_ev.
- The top level instantiates 2*drvrs copies in a generate loop and owns the sticky flag registers.

Test Plan (drvrs=4, pckg_sz=16, depth=4):
- Reset then idle → all pndng=0, rx_valid=0, counts=0, flags=0, D_pop=0.
- Ch0: tx_wr 0x0A01, 0x0A02, 0x0A03 on consecutive cycles, then pop ×3 → pndng=1 from cycle 1; D_pop sequence 0x0A01, 0x0A02, 0x0A03; tx_count 1,2,3,2,1,0; pndng=0 at the end.
- Ch2: write 5 words 0x2001..0x2005 with ovf_mode=0 → tx_count=4, ovf_flag[2]=1, pops return 0x2001..0x2004. Repeat with ovf_mode=1 → pops return 0x2002..0x2005.
- Ch1 full (4 words) with simultaneous tx_wr 0x1005 and pop → tx_count stays 4, ovf_flag[1]=0, next pops return words 2..4 then 0x1005.
- Ch3 RX: pop/rx_rd on empty together with push D_push=0x3333 → udf_flag[3]=1, rx_count=1, rx_rdata=0x3333 next cycle. clr_flags → udf_flag[3]=0.
- Fill ch0 TX to 3 words, assert reset=0 for one cycle mid-stream → counts=0 and pndng=0 immediately (asynchronously). A tx_wr 0xBEEF on the first edge after release → D_pop=0xBEEF.
